pipelined_addsub: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor. It is the sequential successor to the team's single-bit full/half adders. The operand is split into STAGES equal chunks, and each pipeline stage adds one chunk with the carry registered from the stage before. Valid/ready handshakes on input and output let it sit directly in datapath pipelines such as ALU and accumulator fronts.

---
 rtl/pipelined_addsub.sv | 112 +++++++++++
 tb/tb_pipelined_addsub.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - pipelined ripple-carry adder/subtractor with valid/ready handshake
// Each stage adds one CHUNK-wide slice; operands and partial sums travel forward with their carry.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  generate
    if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
      $error("pipelined_addsub: WIDTH must be >= 2 and divisible by STAGES");
    end
  endgenerate

  logic              advance;

  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;
  logic              ovf_q;

  logic [WIDTH-1:0]  a_x [STAGES];
  logic [WIDTH-1:0]  b_x [STAGES];
  logic [WIDTH-1:0]  s_x [STAGES];
  logic [STAGES-1:0] c_x;
  logic [STAGES-1:0] v_x;

  logic [WIDTH-1:0]  s_d [STAGES];
  logic [STAGES-1:0] c_d;
  logic              ovf_d;
  logic [CHUNK:0]    part;

  assign advance   = out_ready | ~out_valid;
  assign in_ready  = advance;
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;

  // Stage k's inputs: the conditioned operands for stage 0, else the previous stage register.
  always_comb begin
    c_x     = '0;
    v_x     = '0;
    a_x[0]  = a;
    b_x[0]  = b ^ {WIDTH{sub}};
    s_x[0]  = '0;
    c_x[0]  = cin ^ sub;
    v_x[0]  = in_valid & in_ready;
    for (int k = 1; k < STAGES; k++) begin
      a_x[k] = a_q[k-1];
      b_x[k] = b_q[k-1];
      s_x[k] = s_q[k-1];
      c_x[k] = c_q[k-1];
      v_x[k] = v_q[k-1];
    end
  end

  always_comb begin
    part = '0;
    c_d  = '0;
    for (int k = 0; k < STAGES; k++) begin
      part = {1'b0, a_x[k][k*CHUNK +: CHUNK]} + {1'b0, b_x[k][k*CHUNK +: CHUNK]}
           + {{CHUNK{1'b0}}, c_x[k]};
      s_d[k] = s_x[k];
      s_d[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
      c_d[k] = part[CHUNK];
    end
    // Sign-rule overflow: equivalent to carry into the MSB xor carry out.
    ovf_d = (a_x[STAGES-1][WIDTH-1] == b_x[STAGES-1][WIDTH-1]) &&
            (s_d[STAGES-1][WIDTH-1] != a_x[STAGES-1][WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q   <= '0;
      v_q   <= '0;
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_x[k];
        b_q[k] <= b_x[k];
        s_q[k] <= s_d[k];
      end
      c_q   <= c_d;
      v_q   <= v_x;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - self-checking bench for pipelined_addsub
// A queue-based arithmetic model predicts every result and its stall-adjusted latency.
module tb_pipelined_addsub;

  localparam int W = 32;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_cnt = 0;

  typedef struct {
    logic [W+1:0] res;
    int           t_in;
    int           st_in;
  } exp_t;
  exp_t q[$];
  exp_t e;

  // Returns {ovf, cout, sum} straight from the arithmetic definition.
  function automatic logic [W+1:0] model(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic s);
    logic [W-1:0] yb;
    logic         c0;
    logic [W:0]   full;
    logic [W-1:0] low;
    yb   = s ? ~y : y;
    c0   = ci ^ s;
    full = {1'b0, x} + {1'b0, yb} + {{W{1'b0}}, c0};
    low  = {1'b0, x[W-2:0]} + {1'b0, yb[W-2:0]} + {{(W-1){1'b0}}, c0};
    return {low[W-1] ^ full[W], full[W], full[W-1:0]};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  logic [W+1:0] held;
  logic         was_stall = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      was_stall = 1'b0;
      chk("reset_out", {out_valid, cout, ovf, sum}, 64'd0);
    end else begin
      chk("in_ready", in_ready, out_ready || !out_valid);
      if (was_stall) chk("hold", {out_valid, ovf, cout, sum}, {1'b1, held});
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          e = q.pop_front();
          chk("result", {ovf, cout, sum}, e.res);
          chk("latency", cyc - e.t_in, S + stall_cnt - e.st_in);
        end
      end
      was_stall = out_valid && !out_ready;
      held = {ovf, cout, sum};
      if (was_stall) stall_cnt++;
      if (in_valid && in_ready) q.push_back('{model(a, b, cin, sub), cyc, stall_cnt});
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s);
    int   n;
    logic acc;
    n = 0;
    a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) chk("drain_timeout", 0, 1);
  endtask

  task automatic directed(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                          input logic s, input logic [W-1:0] es, input logic ec, input logic eo);
    int n;
    chk("model_pin", model(x, y, ci, s), {eo, ec, es});
    wait_empty();
    out_ready = 1'b1;
    send(x, y, ci, s);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    chk("dir_latency", n, S);
    chk("dir_result", {ovf, cout, sum}, {eo, ec, es});
    @(posedge clk);
    #1;
  endtask

  logic         rnd_done = 1'b0;
  logic [W+1:0] held0;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {out_valid, sum, cout, ovf, in_ready}, {1'b0, 32'h0, 1'b0, 1'b0, 1'b1});
    rst_n = 1'b1;

    directed(32'h0000_00FF, 32'h1, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    directed(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    directed(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    directed(32'd5,         32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    directed(32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    directed(32'd10,        32'd3, 1'b1, 1'b1, 32'd6,         1'b1, 1'b0);

    for (int i = 0; i < 16; i++)
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    wait_empty();

    fork
      begin
        for (int i = 0; i < 8; i++)
          send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!out_valid && n < 50);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        held0 = {ovf, cout, sum};
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("bp_in_ready", in_ready, 0);
          chk("bp_sum_held", {ovf, cout, sum}, held0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_empty();

    fork
      begin
        for (int i = 0; i < 40; i++)
          send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_empty();

    for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {out_valid, sum, cout, ovf}, 64'd0);
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1;
    directed(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
